// File: rtl/tile_fetch_scheduler_if.sv
// Pixel-stream and image-ROM bus of the tile fetch scheduler.
// master = sync generator / ROM side, slave = the scheduler itself.
`timescale 1ns/1ps
interface tile_fetch_scheduler_if;
    logic        pix_tick_i;
    logic [9:0]  pixel_x_i;
    logic [9:0]  pixel_y_i;
    logic        video_on_i;
    logic        hsync_i;
    logic        vsync_i;
    logic [15:0] rom_addr_o;
    logic [7:0]  rom_data_i;
    logic [7:0]  rgb_o;
    logic        hsync_o;
    logic        vsync_o;

    modport master (
        output pix_tick_i, pixel_x_i, pixel_y_i, video_on_i, hsync_i, vsync_i, rom_data_i,
        input  rom_addr_o, rgb_o, hsync_o, vsync_o
    );

    modport slave (
        input  pix_tick_i, pixel_x_i, pixel_y_i, video_on_i, hsync_i, vsync_i, rom_data_i,
        output rom_addr_o, rgb_o, hsync_o, vsync_o
    );
endinterface

// File: rtl/tile_fetch_scheduler.sv
// Tile fetch scheduler: maps the current pixel onto one of nine fixed
// tiles, fetches the image word from a shared ROM and emits the colour
// two pixel ticks later together with the delayed sync pulses.
`timescale 1ns/1ps
module tile_fetch_scheduler #(
    parameter int          TILE_W     = 80,
    parameter int          TILE_WORDS = 6400,
    parameter logic [7:0]  BG_COLOUR  = 8'h1A
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [8:0]            tile_en_i,
    input  logic [3:0]            hilite_sel_i,
    tile_fetch_scheduler_if.slave bus
);
    localparam logic [10:0] TW11     = 11'(TILE_W);
    localparam logic [15:0] TW16     = 16'(TILE_W);
    localparam logic [15:0] TWORDS16 = 16'(TILE_WORDS);

    typedef enum logic {ST_WAIT_SYNC = 1'b0, ST_RUN = 1'b1} state_t;

    // Tile origins, x coordinate
    function automatic logic [10:0] origin_x(input logic [3:0] n);
        case (n)
            4'd0:    origin_x = 11'd0;
            4'd1:    origin_x = 11'd200;
            4'd2:    origin_x = 11'd280;
            4'd3:    origin_x = 11'd360;
            4'd4:    origin_x = 11'd200;
            4'd5:    origin_x = 11'd280;
            4'd6:    origin_x = 11'd360;
            4'd7:    origin_x = 11'd280;
            4'd8:    origin_x = 11'd0;
            default: origin_x = 11'd0;
        endcase
    endfunction

    // Tile origins, y coordinate
    function automatic logic [10:0] origin_y(input logic [3:0] n);
        case (n)
            4'd0, 4'd1, 4'd2, 4'd3: origin_y = 11'd0;
            4'd4, 4'd5, 4'd6:       origin_y = 11'd160;
            4'd7, 4'd8:             origin_y = 11'd320;
            default:                origin_y = 11'd0;
        endcase
    endfunction

    // Geometric containment of (x,y) in tile n
    function automatic logic tile_hit(input logic [3:0] n, input logic [10:0] x, input logic [10:0] y);
        tile_hit = (x >= origin_x(n)) && (x < origin_x(n) + TW11) &&
                   (y >= origin_y(n)) && (y < origin_y(n) + TW11);
    endfunction

    state_t      r_state;
    logic [4:0]  r_frame_cnt;
    logic [8:0]  r_mask;
    logic [3:0]  r_hilite;
    logic        r_vs_prev;
    logic        r_s1_von, r_s1_hit, r_s1_inv, r_s1_hs, r_s1_vs;
    logic [15:0] r_rom_addr;
    logic [7:0]  r_rgb;
    logic        r_hs, r_vs;

    logic [10:0] w_x, w_y, w_dx, w_dy;
    logic [8:0]  w_tile_hit;
    logic [3:0]  w_idx;
    logic        w_hit;
    logic [15:0] w_addr;
    logic        w_frame_start;
    logic [8:0]  w_mask_eff;
    logic [3:0]  w_hilite_eff;
    logic [4:0]  w_cnt_eff;

    assign w_x = {1'b0, bus.pixel_x_i};
    assign w_y = {1'b0, bus.pixel_y_i};

    // Per-tile hit vector, then lowest-index winner
    always_comb begin
        w_tile_hit = 9'h000;
        w_idx      = 4'd0;
        for (int n = 0; n < 9; n++) begin
            w_tile_hit[n] = tile_hit(4'(n), w_x, w_y);
        end
        for (int n = 8; n >= 0; n--) begin
            w_idx = w_tile_hit[n] ? 4'(n) : w_idx;
        end
    end

    assign w_hit  = |w_tile_hit;
    assign w_dx   = w_x - origin_x(w_idx);
    assign w_dy   = w_y - origin_y(w_idx);
    assign w_addr = ({12'd0, w_idx} * TWORDS16) + ({5'd0, w_dx} * TW16) + {5'd0, w_dy};

    // A frame start takes effect on the pixel registered in the same tick,
    // so stage 1 sees the freshly latched controls rather than the old ones.
    assign w_frame_start = r_vs_prev & ~bus.vsync_i;
    assign w_mask_eff    = w_frame_start ? tile_en_i    : r_mask;
    assign w_hilite_eff  = w_frame_start ? hilite_sel_i : r_hilite;
    assign w_cnt_eff     = w_frame_start ? (r_frame_cnt + 5'd1) : r_frame_cnt;

    // Control FSM: frame-start detection, per-frame latches, frame counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ST_WAIT_SYNC;
            r_frame_cnt <= 5'd0;
            r_mask      <= 9'h1FF;
            r_hilite    <= 4'hF;
            r_vs_prev   <= 1'b0;
        end else if (bus.pix_tick_i) begin
            r_vs_prev   <= bus.vsync_i;
            r_frame_cnt <= w_cnt_eff;
            r_mask      <= w_mask_eff;
            r_hilite    <= w_hilite_eff;
            if (w_frame_start) begin
                case (r_state)
                    ST_WAIT_SYNC: r_state <= ST_RUN;
                    ST_RUN:       r_state <= ST_RUN;
                    default:      r_state <= ST_WAIT_SYNC;
                endcase
            end else begin
                r_state <= r_state;
            end
        end else begin
            r_state <= r_state;
        end
    end

    // Two-stage pixel pipeline: address/flags, then colour selection
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rom_addr <= 16'h0000;
            r_s1_von   <= 1'b0;
            r_s1_hit   <= 1'b0;
            r_s1_inv   <= 1'b0;
            r_s1_hs    <= 1'b1;
            r_s1_vs    <= 1'b1;
            r_rgb      <= 8'h00;
            r_hs       <= 1'b1;
            r_vs       <= 1'b1;
        end else if (bus.pix_tick_i) begin
            if (w_hit) begin
                r_rom_addr <= w_addr;
            end else begin
                r_rom_addr <= r_rom_addr;
            end
            r_s1_von <= bus.video_on_i;
            r_s1_hit <= w_hit & w_mask_eff[w_idx];
            r_s1_inv <= (w_hilite_eff == w_idx) & w_cnt_eff[4];
            r_s1_hs  <= bus.hsync_i;
            r_s1_vs  <= bus.vsync_i;
            r_hs     <= r_s1_hs;
            r_vs     <= r_s1_vs;
            if (r_state == ST_WAIT_SYNC) begin
                r_rgb <= 8'h00;
            end else if (!r_s1_von) begin
                r_rgb <= 8'h00;
            end else if (r_s1_hit && r_s1_inv) begin
                r_rgb <= ~bus.rom_data_i;
            end else if (r_s1_hit) begin
                r_rgb <= bus.rom_data_i;
            end else begin
                r_rgb <= BG_COLOUR;
            end
        end else begin
            r_rgb <= r_rgb;
        end
    end

    assign bus.rom_addr_o = r_rom_addr;
    assign bus.rgb_o      = r_rgb;
    assign bus.hsync_o    = r_hs;
    assign bus.vsync_o    = r_vs;
endmodule
